// File: rtl/controlador_maquina.sv
// controlador_maquina: digit sequencer and A/B arbiter in front of maquina, with failed-attempt lockout.
// Optional macro PRIORIDADE_FIXA_EN: A always beats B (fixed priority) instead of round-robin.
module controlador_maquina #(
   parameter int HOLD        = 2,
   parameter int GAP         = 1,
   parameter int DIGITOS     = 4,
   parameter int MAX_FALHAS  = 3,
   parameter int LOCK_CYCLES = 20
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              req_a,
   input  logic [4:1]                        num_a,
   output logic                              ack_a,
   input  logic                              req_b,
   input  logic [4:1]                        num_b,
   output logic                              ack_b,
   input  logic                              led_in,
   output logic                              insere,
   output logic [4:1]                        numero,
   output logic                              ocupado,
   output logic                              acerto,
   output logic                              bloqueado,
   output logic [$clog2(MAX_FALHAS+1)-1:0]   falhas
);
   localparam int FW   = $clog2(MAX_FALHAS + 1);
   localparam int CW   = $clog2(DIGITOS + 1);
   localparam int TMAX = HOLD > GAP ? (HOLD > LOCK_CYCLES ? HOLD : LOCK_CYCLES)
                                    : (GAP > LOCK_CYCLES ? GAP : LOCK_CYCLES);
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {OCIOSO, INSERE, PAUSA, VERIFICA, BLOQUEIO} state_t;

   state_t        state;
   logic [TW-1:0] t;
   logic [CW-1:0] cnt;
   logic          pick_b;

`ifdef PRIORIDADE_FIXA_EN
   assign pick_b = req_b & ~req_a;
`else
   logic ptr;
   // ptr=1 means B wins the next tie
   assign pick_b = req_b & (~req_a | ptr);
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= OCIOSO;
         t         <= '0;
         cnt       <= '0;
         insere    <= 1'b0;
         numero    <= '0;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         ocupado   <= 1'b0;
         acerto    <= 1'b0;
         bloqueado <= 1'b0;
         falhas    <= '0;
`ifndef PRIORIDADE_FIXA_EN
         ptr       <= 1'b0;
`endif
      end else begin
         ack_a  <= 1'b0;
         ack_b  <= 1'b0;
         acerto <= 1'b0;
         case (state)
            OCIOSO:
               if (req_a | req_b) begin
                  ack_a   <= ~pick_b;
                  ack_b   <= pick_b;
                  numero  <= pick_b ? num_b : num_a;
                  insere  <= 1'b1;
                  ocupado <= 1'b1;
                  cnt     <= cnt + 1'b1;
                  t       <= '0;
                  state   <= INSERE;
`ifndef PRIORIDADE_FIXA_EN
                  ptr     <= ~pick_b;
`endif
               end
            INSERE:
               if (t == TW'(HOLD - 1)) begin
                  insere <= 1'b0;
                  t      <= '0;
                  state  <= PAUSA;
               end else
                  t <= t + 1'b1;
            PAUSA:
               if (t == TW'(GAP - 1)) begin
                  t       <= '0;
                  ocupado <= int'(cnt) == DIGITOS;
                  state   <= int'(cnt) == DIGITOS ? VERIFICA : OCIOSO;
               end else
                  t <= t + 1'b1;
            VERIFICA: begin
               cnt <= '0;
               t   <= '0;
               if (led_in) begin
                  acerto  <= 1'b1;
                  falhas  <= '0;
                  ocupado <= 1'b0;
                  state   <= OCIOSO;
               end else if (int'(falhas) + 1 < MAX_FALHAS) begin
                  falhas  <= falhas + 1'b1;
                  ocupado <= 1'b0;
                  state   <= OCIOSO;
               end else begin
                  falhas    <= FW'(MAX_FALHAS);
                  bloqueado <= 1'b1;
                  state     <= BLOQUEIO;
               end
            end
            BLOQUEIO:
               if (t == TW'(LOCK_CYCLES - 1)) begin
                  bloqueado <= 1'b0;
                  falhas    <= '0;
                  ocupado   <= 1'b0;
                  t         <= '0;
                  state     <= OCIOSO;
               end else
                  t <= t + 1'b1;
            default: state <= OCIOSO;
         endcase
      end
endmodule
